// File: rtl/dispense_sequencer_pkg.sv
// Shared types and constants for the candy dispense sequencer.
package candy_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StGap,
      StDone,
      StErr
   } state_e;

   // Product select codes from the Pi
   localparam logic [2:0] SEL_DC0      = 3'd1;
   localparam logic [2:0] SEL_DC1      = 3'd2;
   localparam logic [2:0] SEL_DC2      = 3'd3;
   localparam logic [2:0] SEL_STEP_FWD = 3'd4;
   localparam logic [2:0] SEL_STEP_REV = 3'd5;

   // Default timing at a 12 MHz clock
   localparam int unsigned DEF_STEP_DIV       = 6000;
   localparam int unsigned DEF_STEPS_PER_UNIT = 200;
   localparam int unsigned DEF_DC_ON_CYC      = 6000000;
   localparam int unsigned DEF_GAP_CYC        = 1200000;

   function automatic logic sel_valid(input logic [2:0] s);
      return (s >= SEL_DC0) && (s <= SEL_STEP_REV);
   endfunction

   function automatic logic sel_is_step(input logic [2:0] s);
      return (s == SEL_STEP_FWD) || (s == SEL_STEP_REV);
   endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// Pi-side request lines and motor-side outputs of the dispense sequencer.
interface dispense_sequencer_if;
   logic [2:0] sel;
   logic [1:0] amount;
   logic       candyflag;
   logic       step;
   logic       dir;
   logic [2:0] dc_en;
   logic       handshake;
   logic       busy;
   logic       err;

   // Requester side (Pi / bench)
   modport master (
      output sel, amount, candyflag,
      input  step, dir, dc_en, handshake, busy, err
   );

   // Sequencer side
   modport slave (
      input  sel, amount, candyflag,
      output step, dir, dc_en, handshake, busy, err
   );
endinterface

// File: rtl/dispense_sequencer_step_pulse_gen.sv
// Stepper pulse generator: while en is high, emits STEPS_PER_UNIT step periods of STEP_DIV
// cycles (high for the first half) and pulses done on the last cycle of the last period.
module step_pulse_gen #(
   parameter int unsigned STEP_DIV       = 4,
   parameter int unsigned STEPS_PER_UNIT = 3
) (
   input  logic clk_x1,
   input  logic rst,
   input  logic en,
   output logic step,
   output logic done
);

   localparam int unsigned DivW  = $clog2(STEP_DIV + 1);
   localparam int unsigned StepW = $clog2(STEPS_PER_UNIT + 1);

   localparam logic [DivW-1:0]  DivLast  = DivW'(STEP_DIV - 1);
   localparam logic [DivW-1:0]  DivHalf  = DivW'(STEP_DIV / 2);
   localparam logic [StepW-1:0] StepLast = StepW'(STEPS_PER_UNIT - 1);

   logic [DivW-1:0]  div_q, div_d;
   logic [StepW-1:0] cnt_q, cnt_d;
   logic             period_end;

   assign period_end = (div_q == DivLast);

   // Next-state for the period divider and step counter; both sit at zero while disabled
   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (!en) begin
         div_d = '0;
         cnt_d = '0;
      end else if (period_end) begin
         div_d = '0;
         cnt_d = (cnt_q == StepLast) ? '0 : cnt_q + StepW'(1);
      end else begin
         div_d = div_q + DivW'(1);
      end
   end

   // Outputs decoded from registered counters
   always_comb begin
      step = en && (div_q < DivHalf);
      done = en && period_end && (cnt_q == StepLast);
   end

   // Counter registers
   always_ff @(posedge clk_x1) begin
      if (rst) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dispense_sequencer.sv
// Dispense sequencer: turns a candyflag request from the Pi into a run of DC-motor or stepper
// dispense units, then raises handshake. Optional macro DISPENSE_ABORT_EN lets a falling
// candyflag abort a run in progress.
module dispense_sequencer
   import candy_pkg::*;
#(
   parameter int unsigned STEP_DIV       = DEF_STEP_DIV,
   parameter int unsigned STEPS_PER_UNIT = DEF_STEPS_PER_UNIT,
   parameter int unsigned DC_ON_CYC      = DEF_DC_ON_CYC,
   parameter int unsigned GAP_CYC        = DEF_GAP_CYC
) (
   input  logic          clk_x1,
   input  logic          rst,
   dispense_sequencer_if.slave bus
);

   localparam int unsigned CntMax = (DC_ON_CYC > GAP_CYC) ? DC_ON_CYC : GAP_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] DcLast  = CntW'(DC_ON_CYC - 1);
   localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYC - 1);

   logic            cf_s1_q, cf_s2_q, cf_d_q;
   logic            rise, fall;
   state_e          state_q, state_d;
   logic [2:0]      sel_q, sel_d;
   logic [2:0]      units_q, units_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            stepping, step_en, step_raw, step_done, unit_end;

   assign rise = cf_s2_q & ~cf_d_q;
   assign fall = ~cf_s2_q & cf_d_q;

   assign stepping = sel_is_step(sel_q);
   assign step_en  = (state_q == StRun) && stepping;
   assign unit_end = stepping ? step_done : (cnt_q == DcLast);

   step_pulse_gen #(
      .STEP_DIV       (STEP_DIV),
      .STEPS_PER_UNIT (STEPS_PER_UNIT)
   ) u_step (
      .clk_x1 (clk_x1),
      .rst    (rst),
      .en     (step_en),
      .step   (step_raw),
      .done   (step_done)
   );

   // candyflag synchronizer. The sync stages are not reset and cf_d is forced high in reset,
   // so a level held high across reset cannot look like a fresh rise.
   always_ff @(posedge clk_x1) begin
      cf_s1_q <= bus.candyflag;
      cf_s2_q <= cf_s1_q;
      if (rst) cf_d_q <= 1'b1;
      else     cf_d_q <= cf_s2_q;
   end

   // FSM next-state, request latching and cycle counter
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      units_d = units_q;
      unique case (state_q)
         StIdle: begin
            if (rise) begin
               if (sel_valid(bus.sel)) begin
                  sel_d   = bus.sel;
                  units_d = {1'b0, bus.amount} + 3'd1;
                  state_d = StRun;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StRun: begin
            if (unit_end) begin
               units_d = units_q - 3'd1;
               state_d = (units_q == 3'd1) ? StDone : StGap;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) state_d = StRun;
         end
         StDone, StErr: begin
            if (!cf_s2_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
`ifdef DISPENSE_ABORT_EN
      if (((state_q == StRun) || (state_q == StGap)) && fall) state_d = StIdle;
`endif
      // Counter only runs for timed DC bursts and gaps; any state change restarts it
      if ((state_d != state_q) || !((state_q == StGap) || (state_q == StRun && !stepping))) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

`ifndef DISPENSE_ABORT_EN
   logic unused_fall;
   assign unused_fall = fall;
`endif

   // Motor and status outputs, decoded from registered state only
   always_comb begin
      bus.dc_en     = 3'b000;
      bus.step      = step_raw;
      bus.dir       = ((state_q == StRun) || (state_q == StGap)) && (sel_q == SEL_STEP_FWD);
      bus.busy      = (state_q == StRun) || (state_q == StGap);
      bus.handshake = (state_q == StDone);
      bus.err       = (state_q == StErr);
      if (state_q == StRun) begin
         case (sel_q)
            SEL_DC0: bus.dc_en = 3'b001;
            SEL_DC1: bus.dc_en = 3'b010;
            SEL_DC2: bus.dc_en = 3'b100;
            default: bus.dc_en = 3'b000;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk_x1) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= 3'd0;
         units_q <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         units_q <= units_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with small timing parameters
// (STEP_DIV=4, STEPS_PER_UNIT=3, DC_ON_CYC=10, GAP_CYC=5).
module tb_dispense_sequencer;

   logic clk_x1 = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   dispense_sequencer_if bus ();

   dispense_sequencer #(
      .STEP_DIV       (4),
      .STEPS_PER_UNIT (3),
      .DC_ON_CYC      (10),
      .GAP_CYC        (5)
   ) dut (
      .clk_x1 (clk_x1),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_x1 = ~clk_x1;

   // Advance one edge and sample 1 ns after it
   task automatic tick();
      @(posedge clk_x1);
      #1;
   endtask

   // Compare packed {dc_en, step, dir, busy, handshake, err}
   task automatic chk_out(input string tag, input logic [2:0] dc, input logic st,
                          input logic dr, input logic bz, input logic hs, input logic er);
      logic [7:0] obs, exp;
      obs = {bus.dc_en, bus.step, bus.dir, bus.busy, bus.handshake, bus.err};
      exp = {dc, st, dr, bz, hs, er};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed {dc,step,dir,busy,hs,err}=%b expected %b", tag, obs, exp);
      end
   endtask

   // Raise candyflag; returns sampled just after the third edge
   task automatic request(input logic [2:0] s, input logic [1:0] a, input string tag);
      bus.sel       = s;
      bus.amount    = a;
      bus.candyflag = 1'b1;
      tick();
      tick();
      chk_out({tag, "_latency"}, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic dc_unit(input logic [2:0] dc, input string tag);
      for (int i = 0; i < 10; i++) begin
         chk_out(tag, dc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic gap(input logic dr, input string tag);
      for (int i = 0; i < 5; i++) begin
         chk_out(tag, 3'b000, 1'b0, dr, 1'b1, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic step_unit(input logic dr, input string tag);
      for (int j = 0; j < 12; j++) begin
         chk_out(tag, 3'b000, ((j % 4) < 2), dr, 1'b1, 1'b0, 1'b0);
         tick();
      end
   endtask

   // Drop candyflag; hs/err persist for the two synchronizer cycles, then idle
   task automatic release_cf(input logic hs, input logic er, input string tag);
      bus.candyflag = 1'b0;
      tick();
      chk_out({tag, "_hold1"}, 3'b000, 1'b0, 1'b0, 1'b0, hs, er);
      tick();
      chk_out({tag, "_hold2"}, 3'b000, 1'b0, 1'b0, 1'b0, hs, er);
      tick();
      chk_out({tag, "_idle"}, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.sel       = 3'd0;
      bus.amount    = 2'd0;
      bus.candyflag = 1'b0;
      tick();
      tick();
      tick();
      chk_out("reset", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      tick();

      // Single DC0 unit
      request(3'd1, 2'd0, "dc0");
      dc_unit(3'b001, "dc0_run");
      chk_out("dc0_done", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("dc0_done_held", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("dc0_no_retrigger", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      release_cf(1'b1, 1'b0, "dc0_rel");

      // Three DC2 units with gaps
      request(3'd3, 2'd2, "dc2");
      dc_unit(3'b100, "dc2_u1");
      gap(1'b0, "dc2_g1");
      dc_unit(3'b100, "dc2_u2");
      gap(1'b0, "dc2_g2");
      dc_unit(3'b100, "dc2_u3");
      chk_out("dc2_done", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      release_cf(1'b1, 1'b0, "dc2_rel");

      // Stepper forward, two units
      request(3'd4, 2'd1, "fwd");
      step_unit(1'b1, "fwd_u1");
      gap(1'b1, "fwd_g1");
      step_unit(1'b1, "fwd_u2");
      chk_out("fwd_done", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      release_cf(1'b1, 1'b0, "fwd_rel");

      // Stepper reverse, two units
      request(3'd5, 2'd1, "rev");
      step_unit(1'b0, "rev_u1");
      gap(1'b0, "rev_g1");
      step_unit(1'b0, "rev_u2");
      chk_out("rev_done", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      release_cf(1'b1, 1'b0, "rev_rel");

      // Invalid select
      request(3'd7, 2'd0, "bad");
      for (int i = 0; i < 4; i++) begin
         chk_out("bad_err", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
      end
      release_cf(1'b0, 1'b1, "bad_rel");

      // Reset in cycle 4 of a DC1 burst, candyflag held high through it
      request(3'd2, 2'd0, "rst");
      for (int i = 0; i < 4; i++) begin
         chk_out("rst_run", 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         if (i < 3) tick();
      end
      rst = 1'b1;
      tick();
      chk_out("rst_stop", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_out("rst_no_restart", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      bus.candyflag = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      request(3'd2, 2'd0, "rst_again");
      dc_unit(3'b010, "rst_again_run");
      chk_out("rst_again_done", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      release_cf(1'b1, 1'b0, "rst_again_rel");

      // candyflag drops during the first of two DC0 units
      request(3'd1, 2'd1, "drop");
      for (int i = 0; i < 4; i++) begin
         chk_out("drop_run", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         if (i < 3) tick();
      end
      bus.candyflag = 1'b0;
      tick();
`ifdef DISPENSE_ABORT_EN
      tick();
      tick();
      chk_out("abort_stop", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++) begin
         tick();
         chk_out("abort_no_hs", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
`else
      for (int i = 4; i < 10; i++) begin
         chk_out("drop_u1", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      gap(1'b0, "drop_g1");
      dc_unit(3'b001, "drop_u2");
      chk_out("drop_done", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("drop_idle", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
